// File: rtl/vlsu_mem_arbiter.sv
// Two-requester arbiter for the shared 256-bit data RAM port: round-robin grants,
// lock holding for multi-beat unaligned accesses with a watchdog, and read-data return routing.
module vlsu_mem_arbiter #(
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic         lock0,
   input  logic         lock1,
   input  logic         rden0,
   input  logic         rden1,
   input  logic         wren0,
   input  logic         wren1,
   input  logic [13:0]  addr0,
   input  logic [13:0]  addr1,
   input  logic [31:0]  byteena0,
   input  logic [31:0]  byteena1,
   input  logic [255:0] wdata0,
   input  logic [255:0] wdata1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         rvalid0,
   output logic         rvalid1,
   output logic [255:0] rdata,
   output logic         ram_rden,
   output logic         ram_wren,
   output logic [13:0]  ram_address,
   output logic [31:0]  ram_byteena,
   output logic [255:0] ram_wdata,
   input  logic [255:0] ram_rdata,
   output logic         lock_timeout
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

   state_e      state_q, state_d;
   logic        last_owner_q, last_owner_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic        lock_timeout_q, lock_timeout_d;
   logic        rd_pend_q;
   logic        rd_tag_q;
   logic        hold_below;

   assign hold_below = (hold_cnt_q < 4'(MAX_LOCK - 1));

   // A locked owner keeps the port until the watchdog budget runs out; a waiting
   // competitor then takes it directly and the forced release is recorded.
   always_comb begin
      state_d        = state_q;
      last_owner_d   = last_owner_q;
      lock_timeout_d = lock_timeout_q;
      case (state_q)
         IDLE: begin
            if (req0 && req1)  state_d = last_owner_q ? GNT0 : GNT1;
            else if (req0)     state_d = GNT0;
            else if (req1)     state_d = GNT1;
         end
         GNT0: begin
            if (req0 && lock0 && hold_below) state_d = GNT0;
            else if (req1) begin
               state_d = GNT1;
               if (req0 && lock0) lock_timeout_d = 1'b1;
            end
            else if (req0) state_d = GNT0;
            else           state_d = IDLE;
         end
         GNT1: begin
            if (req1 && lock1 && hold_below) state_d = GNT1;
            else if (req0) begin
               state_d = GNT0;
               if (req1 && lock1) lock_timeout_d = 1'b1;
            end
            else if (req1) state_d = GNT1;
            else           state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q && state_q != IDLE) last_owner_d = (state_q == GNT1);

      if (state_d != state_q || state_q == IDLE) hold_cnt_d = 4'd0;
      else if (hold_cnt_q == 4'd15)              hold_cnt_d = 4'd15;
      else                                       hold_cnt_d = hold_cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         last_owner_q   <= 1'b1;
         hold_cnt_q     <= 4'd0;
         lock_timeout_q <= 1'b0;
         rd_pend_q      <= 1'b0;
         rd_tag_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_owner_q   <= last_owner_d;
         hold_cnt_q     <= hold_cnt_d;
         lock_timeout_q <= lock_timeout_d;
         rd_pend_q      <= ram_rden;
         rd_tag_q       <= (state_q == GNT1);
      end
   end

   // The owner's payload drives the RAM; only strobes are qualified by its request.
   always_comb begin
      ram_rden    = 1'b0;
      ram_wren    = 1'b0;
      ram_address = '0;
      ram_byteena = '0;
      ram_wdata   = '0;
      case (state_q)
         GNT0: begin
            ram_rden    = req0 & rden0;
            ram_wren    = req0 & wren0;
            ram_address = addr0;
            ram_byteena = byteena0;
            ram_wdata   = wdata0;
         end
         GNT1: begin
            ram_rden    = req1 & rden1;
            ram_wren    = req1 & wren1;
            ram_address = addr1;
            ram_byteena = byteena1;
            ram_wdata   = wdata1;
         end
         default: ;
      endcase
   end

   assign gnt0         = (state_q == GNT0);
   assign gnt1         = (state_q == GNT1);
   assign rvalid0      = rd_pend_q & ~rd_tag_q;
   assign rvalid1      = rd_pend_q & rd_tag_q;
   assign rdata        = rd_pend_q ? ram_rdata : '0;
   assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_vlsu_mem_arbiter.sv
// Randomized bench for vlsu_mem_arbiter, checked every cycle against a behavioural
// model of grant ownership, lock budget, watchdog and read return.
module tb_vlsu_mem_arbiter;

   localparam int MAX_LOCK = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0, req1, lock0, lock1, rden0, rden1, wren0, wren1;
   logic [13:0]  addr0, addr1;
   logic [31:0]  byteena0, byteena1;
   logic [255:0] wdata0, wdata1;
   logic         gnt0, gnt1, rvalid0, rvalid1;
   logic [255:0] rdata;
   logic         ram_rden, ram_wren;
   logic [13:0]  ram_address;
   logic [31:0]  ram_byteena;
   logic [255:0] ram_wdata;
   logic [255:0] ram_rdata;
   logic         lock_timeout;

   int compared = 0;
   int mismatched = 0;

   // Model: current owner (-1 none), cycles held beyond the first, last owner, sticky flag, pending read
   int mOwner, mRun, mLast, mRdTag;
   bit mTimeout, mRdPend;

   vlsu_mem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
      .rden0(rden0), .rden1(rden1), .wren0(wren0), .wren1(wren1),
      .addr0(addr0), .addr1(addr1), .byteena0(byteena0), .byteena1(byteena1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_address(ram_address),
      .ram_byteena(ram_byteena), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .lock_timeout(lock_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic modelReset();
      mOwner = -1; mRun = 0; mLast = 1; mTimeout = 0; mRdPend = 0; mRdTag = 0;
   endtask

   // Advance the model by one clock using the inputs the DUT sampled at this edge.
   task automatic modelUpdate();
      bit [1:0] rq, lk, rd;
      int nxt, x, y;
      rq = {req1, req0}; lk = {lock1, lock0}; rd = {rden1, rden0};
      if (reset) begin
         mRdPend = (mOwner >= 0) && rq[mOwner] && rd[mOwner];
         mRdTag  = (mOwner == 1) ? 1 : 0;
         if (mOwner < 0) begin
            if (rq == 2'b11)   nxt = 1 - mLast;
            else if (rq[0])    nxt = 0;
            else if (rq[1])    nxt = 1;
            else               nxt = -1;
         end else begin
            x = mOwner; y = 1 - mOwner;
            if (rq[x] && lk[x] && mRun < MAX_LOCK - 1) nxt = x;
            else if (rq[y]) begin
               nxt = y;
               if (rq[x] && lk[x]) mTimeout = 1;
            end
            else if (rq[x]) nxt = x;
            else nxt = -1;
         end
         if (nxt != mOwner) begin
            if (mOwner >= 0) mLast = mOwner;
            mRun = 0;
         end else if (mOwner >= 0 && mRun < 15) mRun++;
         mOwner = nxt;
      end
   endtask

   task automatic applyStimulus(input bit [1:0] rq, input bit [1:0] lk, input bit [1:0] rd,
                                input bit [1:0] wr, input logic [13:0] a0, input logic [13:0] a1);
      req0 = rq[0]; req1 = rq[1]; lock0 = lk[0]; lock1 = lk[1];
      rden0 = rd[0]; rden1 = rd[1]; wren0 = wr[0] & ~rd[0]; wren1 = wr[1] & ~rd[1];
      addr0 = a0; addr1 = a1;
      byteena0 = $urandom; byteena1 = $urandom;
      wdata0 = rand256(); wdata1 = rand256();
   endtask

   task automatic checkAll();
      logic eRd, eWr;
      logic [13:0] eAddr;
      logic [31:0] eBe;
      logic [255:0] eWd;
      @(negedge clk);
      eRd = 0; eWr = 0; eAddr = '0; eBe = '0; eWd = '0;
      if (mOwner == 0) begin
         eRd = req0 & rden0; eWr = req0 & wren0; eAddr = addr0; eBe = byteena0; eWd = wdata0;
      end else if (mOwner == 1) begin
         eRd = req1 & rden1; eWr = req1 & wren1; eAddr = addr1; eBe = byteena1; eWd = wdata1;
      end
      checkOutput("gnt0", gnt0, mOwner == 0);
      checkOutput("gnt1", gnt1, mOwner == 1);
      checkOutput("ram_rden", ram_rden, eRd);
      checkOutput("ram_wren", ram_wren, eWr);
      checkOutput("ram_address", ram_address, eAddr);
      checkOutput("ram_byteena", ram_byteena, eBe);
      checkOutput("ram_wdata", ram_wdata, eWd);
      checkOutput("rvalid0", rvalid0, mRdPend && mRdTag == 0);
      checkOutput("rvalid1", rvalid1, mRdPend && mRdTag == 1);
      if (mRdPend) checkOutput("rdata", rdata, ram_rdata);
      checkOutput("lock_timeout", lock_timeout, mTimeout);
   endtask

   task automatic cycle(input bit [1:0] rq, input bit [1:0] lk, input bit [1:0] rd,
                        input bit [1:0] wr, input logic [13:0] a0, input logic [13:0] a1);
      @(posedge clk);
      modelUpdate();
      #1;
      ram_rdata = rand256();
      applyStimulus(rq, lk, rd, wr, a0, a1);
      checkAll();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
      checkOutput({tag, "_rvalid"}, {rvalid1, rvalid0}, 2'b00);
      checkOutput({tag, "_strobes"}, {ram_wren, ram_rden}, 2'b00);
      checkOutput({tag, "_addr"}, ram_address, 14'h0);
      checkOutput({tag, "_be"}, ram_byteena, 32'h0);
      checkOutput({tag, "_wdata"}, ram_wdata, 256'h0);
      checkOutput({tag, "_rdata"}, rdata, 256'h0);
      checkOutput({tag, "_timeout"}, lock_timeout, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      ram_rdata = '0;
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);
      modelReset();
      repeat (3) checkAll();
      checkAllZero("reset");
      reset = 1'b1;

      // Single read by requester 0
      $display("[TB] single read");
      cycle(2'b01, 2'b00, 2'b01, 2'b00, 14'h0010, 14'h0);
      cycle(2'b01, 2'b00, 2'b01, 2'b00, 14'h0010, 14'h0);
      cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);
      cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);

      // Continuous tie, no lock
      $display("[TB] tie round robin");
      repeat (8) cycle(2'b11, 2'b00, 2'b00, 2'b00, 14'($urandom), 14'($urandom));
      repeat (2) cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);

      // Locked unaligned write pair with requester 1 waiting
      $display("[TB] locked pair");
      cycle(2'b11, 2'b01, 2'b00, 2'b01, 14'd5, 14'd9);
      cycle(2'b11, 2'b01, 2'b00, 2'b01, 14'd5, 14'd9);
      cycle(2'b11, 2'b00, 2'b00, 2'b01, 14'd6, 14'd9);
      cycle(2'b10, 2'b00, 2'b00, 2'b00, 14'd0, 14'd9);
      repeat (2) cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);

      // Read return across a grant switch
      $display("[TB] read across switch");
      cycle(2'b10, 2'b00, 2'b00, 2'b00, 14'h0, 14'h1234);
      cycle(2'b11, 2'b00, 2'b10, 2'b00, 14'h0001, 14'h3FFF);
      cycle(2'b01, 2'b00, 2'b00, 2'b00, 14'h0001, 14'h0);
      cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);
      repeat (2) cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);

      // Watchdog: requester 0 locks against a waiting requester 1
      $display("[TB] watchdog");
      cycle(2'b01, 2'b01, 2'b00, 2'b01, 14'd7, 14'd0);
      repeat (7) cycle(2'b11, 2'b01, 2'b00, 2'b01, 14'd7, 14'd8);
      repeat (3) cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);
      checkOutput("wd_sticky", lock_timeout, 1'b1);

      // Randomized traffic with varying lock pressure
      $display("[TB] random traffic");
      for (int p = 0; p < 4; p++) begin
         for (int n = 0; n < 120; n++) begin
            bit [1:0] rq, lk, rd, wr;
            rq = {2'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            lk = {1'($urandom_range(0, 3) < p), 1'($urandom_range(0, 3) < p)};
            rd = 2'($urandom); wr = 2'($urandom);
            cycle(rq, lk, rd, wr, 14'($urandom), 14'($urandom));
         end
      end

      // Reset asserted mid-lock
      $display("[TB] reset mid-lock");
      repeat (2) cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);
      repeat (4) cycle(2'b01, 2'b01, 2'b01, 2'b00, 14'($urandom), 14'h0);
      #1 reset = 1'b0;
      #1;
      modelReset();
      checkAllZero("async_reset");
      applyStimulus(2'b10, 2'b00, 2'b00, 2'b10, 14'h0, 14'h0ABC);
      #1 reset = 1'b1;
      cycle(2'b10, 2'b00, 2'b00, 2'b10, 14'h0, 14'h0ABC);
      checkOutput("post_reset_gnt1", gnt1, 1'b1);
      repeat (3) cycle(2'b00, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
